// File: rtl/draw_pkg.sv
// Drawing-stage geometry shared by the sprite pipeline.
// Holds the glove sprite size, the goal window and the auto-keeper speed.
package draw_pkg;

    localparam int GLOVES_LENGTH   = 64;
    localparam int GLOVES_WIDTH    = 48;

    localparam int GOAL_X_MIN      = 256;
    localparam int GOAL_X_MAX      = 640;
    localparam int GOAL_Y_MIN      = 160;
    localparam int GOAL_Y_MAX      = 400;

    localparam int GLOVES_STEP_MAX = 8;

endpackage

// File: rtl/game_pkg.sv
// Game-level types and timing constants shared by the controllers.
package game_pkg;

    typedef enum logic {
        TRACK = 1'b0,
        HOLD  = 1'b1
    } gloves_state_t;

    localparam int SAVE_HOLD_FRAMES = 60;

endpackage

// File: rtl/gloves_axis_step.sv
// One axis of the gloves motion: clamp the source to the goal window, then
// either jump to it or approach it by at most STEP pixels per frame.
module gloves_axis_step
    import draw_pkg::*;
#(
    parameter int MIN_POS = GOAL_X_MIN,
    parameter int MAX_POS = GOAL_X_MAX,
    parameter int STEP    = GLOVES_STEP_MAX
) (
    input  logic [11:0] i_cur,
    input  logic [11:0] i_src,
    input  logic        i_auto,
    output logic [11:0] o_next
);

    localparam logic [11:0]        LO     = 12'(MIN_POS);
    localparam logic [11:0]        HI     = 12'(MAX_POS);
    localparam logic signed [12:0] STEP_S = 13'(STEP);

    logic [11:0]        w_clamp;
    logic signed [12:0] w_delta;

    // Clamp, then rate-limit toward the clamped value when auto is selected
    always_comb begin
        w_clamp = i_src;
        if (i_src < LO) begin
            w_clamp = LO;
        end else if (i_src > HI) begin
            w_clamp = HI;
        end else begin
            w_clamp = i_src;
        end

        w_delta = $signed({1'b0, w_clamp}) - $signed({1'b0, i_cur});

        if (!i_auto) begin
            o_next = w_clamp;
        end else if (w_delta > STEP_S) begin
            o_next = i_cur + STEP_S[11:0];
        end else if (w_delta < -STEP_S) begin
            o_next = i_cur - STEP_S[11:0];
        end else begin
            o_next = w_clamp;
        end
    end

endmodule

// File: rtl/gloves_ctl.sv
// Frame-synchronous gloves position controller: updates once per vblank edge,
// clamps/rate-limits the selected source and freezes after save/goal events.
module gloves_ctl
    import draw_pkg::*;
    import game_pkg::*;
#(
    parameter int X_MIN       = GOAL_X_MIN,
    parameter int X_MAX       = GOAL_X_MAX,
    parameter int Y_MIN       = GOAL_Y_MIN,
    parameter int Y_MAX       = GOAL_Y_MAX,
    parameter int STEP_MAX    = GLOVES_STEP_MAX,
    parameter int HOLD_FRAMES = SAVE_HOLD_FRAMES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vblnk,
    input  logic [11:0] mouse_xpos,
    input  logic [11:0] mouse_ypos,
    input  logic        auto_mode,
    input  logic [11:0] target_x,
    input  logic [11:0] target_y,
    input  logic        freeze_req,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic        frame_tick,
    output logic        frozen
);

    localparam logic [11:0] X_RST     = 12'((X_MIN + X_MAX) / 2);
    localparam logic [11:0] Y_RST     = 12'((Y_MIN + Y_MAX) / 2);
    localparam logic [15:0] HOLD_LOAD = 16'(HOLD_FRAMES - 1);

    gloves_state_t r_state;
    gloves_state_t w_state_nxt;
    logic          r_vblnk_q;
    logic          r_pend;
    logic          w_pend_nxt;
    logic [15:0]   r_cnt;
    logic [15:0]   w_cnt_nxt;
    logic          w_tick;
    logic [11:0]   w_src_x;
    logic [11:0]   w_src_y;
    logic [11:0]   w_step_x;
    logic [11:0]   w_step_y;
    logic [11:0]   w_x_nxt;
    logic [11:0]   w_y_nxt;

    assign w_tick  = vblnk & ~r_vblnk_q;
    assign w_src_x = auto_mode ? target_x : mouse_xpos;
    assign w_src_y = auto_mode ? target_y : mouse_ypos;

    gloves_axis_step #(
        .MIN_POS (X_MIN),
        .MAX_POS (X_MAX),
        .STEP    (STEP_MAX)
    ) u_step_x (
        .i_cur   (xpos),
        .i_src   (w_src_x),
        .i_auto  (auto_mode),
        .o_next  (w_step_x)
    );

    gloves_axis_step #(
        .MIN_POS (Y_MIN),
        .MAX_POS (Y_MAX),
        .STEP    (STEP_MAX)
    ) u_step_y (
        .i_cur   (ypos),
        .i_src   (w_src_y),
        .i_auto  (auto_mode),
        .o_next  (w_step_y)
    );

    // Next-state logic: position, freeze pending flag and hold counter
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pend_nxt  = r_pend;
        w_x_nxt     = xpos;
        w_y_nxt     = ypos;
        case (r_state)
            TRACK: begin
                // A request arriving in the tick cycle itself still freezes at this tick
                if (w_tick && (r_pend || freeze_req)) begin
                    w_state_nxt = HOLD;
                    w_cnt_nxt   = HOLD_LOAD;
                    w_pend_nxt  = 1'b0;
                end else if (w_tick) begin
                    w_x_nxt = w_step_x;
                    w_y_nxt = w_step_y;
                end else begin
                    w_pend_nxt = r_pend | freeze_req;
                end
            end
            HOLD: begin
                if (w_tick && (r_cnt == 16'd0)) begin
                    w_state_nxt = TRACK;
                end else if (w_tick) begin
                    w_cnt_nxt = r_cnt - 16'd1;
                end else begin
                    w_cnt_nxt = r_cnt;
                end
            end
            default: begin
                w_state_nxt = TRACK;
                w_pend_nxt  = 1'b0;
                w_cnt_nxt   = 16'd0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= TRACK;
            r_vblnk_q  <= 1'b1;
            r_pend     <= 1'b0;
            r_cnt      <= 16'd0;
            xpos       <= X_RST;
            ypos       <= Y_RST;
            frame_tick <= 1'b0;
            frozen     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_vblnk_q  <= vblnk;
            r_pend     <= w_pend_nxt;
            r_cnt      <= w_cnt_nxt;
            xpos       <= w_x_nxt;
            ypos       <= w_y_nxt;
            frame_tick <= w_tick;
            frozen     <= (w_state_nxt == HOLD);
        end
    end

endmodule

// File: tb/tb_gloves_ctl.sv
// Directed bench for gloves_ctl: a frame-level model pushes the expected
// position per tick into a queue that is popped when frame_tick appears.
module tb_gloves_ctl;

    localparam int X_MIN = 256;
    localparam int X_MAX = 640;
    localparam int Y_MIN = 160;
    localparam int Y_MAX = 400;
    localparam int STEP  = 8;
    localparam int HOLD  = 60;

    logic        clk = 1'b0;
    logic        rst;
    logic        vblnk;
    logic        auto_mode;
    logic        freeze_req;
    logic [11:0] mouse_xpos;
    logic [11:0] mouse_ypos;
    logic [11:0] target_x;
    logic [11:0] target_y;
    logic [11:0] xpos;
    logic [11:0] ypos;
    logic        frame_tick;
    logic        frozen;

    typedef struct {
        int x;
        int y;
        bit fz;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   n_ft     = 0;
    int   n_ticks  = 0;
    int   mx, my, mcnt;
    bit   mhold, mpend;

    always #5 clk = ~clk;

    gloves_ctl dut (
        .clk        (clk),
        .rst        (rst),
        .vblnk      (vblnk),
        .mouse_xpos (mouse_xpos),
        .mouse_ypos (mouse_ypos),
        .auto_mode  (auto_mode),
        .target_x   (target_x),
        .target_y   (target_y),
        .freeze_req (freeze_req),
        .xpos       (xpos),
        .ypos       (ypos),
        .frame_tick (frame_tick),
        .frozen     (frozen)
    );

    always @(negedge clk) begin
        if (frame_tick === 1'b1) n_ft++;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int model_step(int cur, int src, int lo, int hi, bit au);
        int c;
        c = (src < lo) ? lo : ((src > hi) ? hi : src);
        if (!au) return c;
        if (c > cur + STEP) return cur + STEP;
        if (c < cur - STEP) return cur - STEP;
        return c;
    endfunction

    task automatic model_reset();
        mx = (X_MIN + X_MAX) / 2;
        my = (Y_MIN + Y_MAX) / 2;
        mhold = 1'b0;
        mpend = 1'b0;
        mcnt  = 0;
        sb.delete();
    endtask

    task automatic model_tick(input bit frz);
        int sx, sy;
        sx = auto_mode ? int'(target_x) : int'(mouse_xpos);
        sy = auto_mode ? int'(target_y) : int'(mouse_ypos);
        if (!mhold) begin
            if (mpend || frz) begin
                mhold = 1'b1;
                mcnt  = HOLD - 1;
                mpend = 1'b0;
            end else begin
                mx = model_step(mx, sx, X_MIN, X_MAX, auto_mode);
                my = model_step(my, sy, Y_MIN, Y_MAX, auto_mode);
            end
        end else if (mcnt == 0) begin
            mhold = 1'b0;
        end else begin
            mcnt--;
        end
        sb.push_back('{mx, my, mhold});
    endtask

    // One frame: vblnk rises, outputs checked one cycle later, vblnk falls
    task automatic do_tick(input bit frz);
        exp_t e;
        @(negedge clk);
        vblnk      = 1'b1;
        freeze_req = frz;
        model_tick(frz);
        n_ticks++;
        @(negedge clk);
        freeze_req = 1'b0;
        chk("frame_tick_hi", 16'(frame_tick), 16'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("sb_xpos", 16'(xpos), 16'(e.x));
            chk("sb_ypos", 16'(ypos), 16'(e.y));
            chk("sb_frozen", 16'(frozen), 16'(e.fz));
        end
        @(negedge clk);
        chk("frame_tick_lo", 16'(frame_tick), 16'd0);
        repeat (2) @(negedge clk);
        vblnk = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic freeze_pulse();
        @(negedge clk);
        freeze_req = 1'b1;
        if (!mhold) mpend = 1'b1;
        @(negedge clk);
        freeze_req = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rst        = 1'b0;
        vblnk      = 1'b1;
        auto_mode  = 1'b0;
        freeze_req = 1'b0;
        mouse_xpos = 12'd0;
        mouse_ypos = 12'd0;
        target_x   = 12'd0;
        target_y   = 12'd0;
        model_reset();

        // Reset released while vblnk is already high: no tick
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_xpos", 16'(xpos), 16'd448);
        chk("rst_ypos", 16'(ypos), 16'd280);
        chk("rst_frozen", 16'(frozen), 16'd0);
        chk("rst_no_tick", 16'(n_ft), 16'd0);
        vblnk = 1'b0;
        repeat (3) @(negedge clk);

        // Mouse mode, direct jump and clamping
        mouse_xpos = 12'd500;
        mouse_ypos = 12'd300;
        do_tick(1'b0);
        chk("mouse_x", 16'(xpos), 16'd500);
        chk("mouse_y", 16'(ypos), 16'd300);
        mouse_xpos = 12'd10;
        mouse_ypos = 12'd4000;
        do_tick(1'b0);
        chk("clamp_x", 16'(xpos), 16'd256);
        chk("clamp_y", 16'(ypos), 16'd400);

        // Source changes between ticks do not move the gloves
        mouse_xpos = 12'd600;
        mouse_ypos = 12'd200;
        auto_mode  = 1'b1;
        repeat (6) @(negedge clk);
        chk("idle_x", 16'(xpos), 16'd256);
        chk("idle_y", 16'(ypos), 16'd400);
        auto_mode = 1'b0;

        // Auto mode rate limit from the reset position
        do_reset();
        auto_mode = 1'b1;
        target_x  = 12'd600;
        target_y  = 12'd283;
        for (int k = 1; k <= 19; k++) begin
            do_tick(1'b0);
            chk("auto_x", 16'(xpos), 16'((448 + 8 * k > 600) ? 600 : 448 + 8 * k));
            chk("auto_y", 16'(ypos), 16'd283);
        end
        target_x = 12'd0;
        target_y = 12'd0;
        for (int k = 0; k < 44; k++) do_tick(1'b0);
        chk("auto_floor_x", 16'(xpos), 16'd256);
        chk("auto_floor_y", 16'(ypos), 16'd160);

        // Freeze for 60 frames; a second request during HOLD is ignored
        auto_mode  = 1'b0;
        mouse_xpos = 12'd500;
        mouse_ypos = 12'd300;
        do_tick(1'b0);
        freeze_pulse();
        mouse_xpos = 12'd300;
        mouse_ypos = 12'd200;
        for (int t = 1; t <= 62; t++) begin
            if (t == 10) freeze_pulse();
            do_tick(1'b0);
            if (t <= 60) begin
                chk("hold_frozen", 16'(frozen), 16'd1);
                chk("hold_x", 16'(xpos), 16'd500);
            end else if (t == 61) begin
                chk("resume_frozen", 16'(frozen), 16'd0);
                chk("resume_x", 16'(xpos), 16'd500);
            end else begin
                chk("first_move_x", 16'(xpos), 16'd300);
                chk("first_move_y", 16'(ypos), 16'd200);
            end
        end

        // Freeze request in the tick cycle, then reset at hold frame 30
        mouse_xpos = 12'd400;
        mouse_ypos = 12'd250;
        do_tick(1'b1);
        chk("same_cycle_frozen", 16'(frozen), 16'd1);
        chk("same_cycle_x", 16'(xpos), 16'd300);
        for (int t = 2; t <= 30; t++) do_tick(1'b0);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midhold_rst_x", 16'(xpos), 16'd448);
        chk("midhold_rst_y", 16'(ypos), 16'd280);
        chk("midhold_rst_frozen", 16'(frozen), 16'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        do_tick(1'b0);
        chk("post_rst_track_x", 16'(xpos), 16'd400);
        chk("post_rst_track_fz", 16'(frozen), 16'd0);

        repeat (3) @(negedge clk);
        chk("tick_count", 16'(n_ft), 16'(n_ticks));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
